// File: rtl/mult_pkg.sv
// Shared constants and types for the 3x3 array multiplier datapath and its I/O stages.
// SERIALIZER_CHECKSUM_EN appends an XOR checksum byte to the result stream.
package mult_pkg;

  localparam int N_ELEM     = 9;
  localparam int ELEM_W     = 18;
  localparam int BYTES_PER  = (ELEM_W + 7) / 8;
  localparam int DATA_BYTES = N_ELEM * BYTES_PER;
`ifdef SERIALIZER_CHECKSUM_EN
  localparam int TOTAL_BYTES = DATA_BYTES + 1;
`else
  localparam int TOTAL_BYTES = DATA_BYTES;
`endif
  localparam int ELEM_IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int BYTE_IDX_W = (BYTES_PER > 1) ? $clog2(BYTES_PER) : 1;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_PRESENT,
    SER_WAIT_ACK_LO,
    SER_DONE
  } ser_state_e;

  // Little-endian byte of an element, zero-extended to a whole number of bytes.
  function automatic logic [7:0] elem_byte(input logic [ELEM_W-1:0]     elem,
                                           input logic [BYTE_IDX_W-1:0] sel);
    logic [BYTES_PER*8-1:0] ext;
    ext = '0;
    ext[ELEM_W-1:0] = elem;
    return ext[sel*8 +: 8];
  endfunction

endpackage

// File: rtl/ack_sync.sv
// Multi-flop synchronizer for an asynchronous handshake pin; flops reset to 0.
// STAGES must be at least 2.
module ack_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/result_serializer.sv
// Streams the nine captured products off-chip one byte per 4-phase valid/ack handshake.
// SERIALIZER_CHECKSUM_EN adds a trailing XOR-of-all-data-bytes byte before done.
module result_serializer
  import mult_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [N_ELEM*ELEM_W-1:0] c_flat,
  input  logic                     ack_in,
  output logic [7:0]               data_out,
  output logic                     valid_out,
  output logic                     busy,
  output logic                     done
);

  localparam logic [ELEM_IDX_W-1:0] LAST_ELEM = ELEM_IDX_W'(N_ELEM - 1);
  localparam logic [BYTE_IDX_W-1:0] LAST_BSEL = BYTE_IDX_W'(BYTES_PER - 1);

  ser_state_e               state_q, state_d;
  logic [N_ELEM*ELEM_W-1:0] shadow_q, shadow_d;
  logic [ELEM_IDX_W-1:0]    elem_q, elem_d, nxt_elem;
  logic [BYTE_IDX_W-1:0]    bsel_q, bsel_d, nxt_bsel;
  logic [7:0]               data_q, data_d;
  logic [7:0]               nxt_byte, first_byte;
  logic                     valid_q, valid_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     ack_s;
  logic                     last_data;
  logic                     last_byte;
`ifdef SERIALIZER_CHECKSUM_EN
  logic [7:0]               chk_q, chk_d;
  logic                     chk_phase_q, chk_phase_d;
`endif

  ack_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (ack_in),
    .sync_o  (ack_s)
  );

  assign last_data = (elem_q == LAST_ELEM) && (bsel_q == LAST_BSEL);
`ifdef SERIALIZER_CHECKSUM_EN
  assign last_byte = chk_phase_q;
`else
  assign last_byte = last_data;
`endif

  // Element index saturates at the last element; only the byte counter wraps.
  always_comb begin
    nxt_elem = elem_q;
    nxt_bsel = bsel_q + 1'b1;
    if (bsel_q == LAST_BSEL) begin
      nxt_bsel = '0;
      if (elem_q != LAST_ELEM) begin
        nxt_elem = elem_q + 1'b1;
      end
    end
  end

  assign nxt_byte   = elem_byte(shadow_q[int'(nxt_elem)*ELEM_W +: ELEM_W], nxt_bsel);
  assign first_byte = elem_byte(c_flat[ELEM_W-1:0], '0);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    elem_d   = elem_q;
    bsel_d   = bsel_q;
    data_d   = data_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = done_q;
`ifdef SERIALIZER_CHECKSUM_EN
    chk_d       = chk_q;
    chk_phase_d = chk_phase_q;
`endif

    case (state_q)
      SER_IDLE, SER_DONE: begin
        if (start) begin
          shadow_d = c_flat;
          elem_d   = '0;
          bsel_d   = '0;
          data_d   = first_byte;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          state_d  = SER_PRESENT;
`ifdef SERIALIZER_CHECKSUM_EN
          chk_d       = first_byte;
          chk_phase_d = 1'b0;
`endif
        end
      end

      SER_PRESENT: begin
        if (ack_s) begin
          valid_d = 1'b0;
          state_d = SER_WAIT_ACK_LO;
        end
      end

      SER_WAIT_ACK_LO: begin
        if (!ack_s) begin
          if (last_byte) begin
            data_d  = 8'h00;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = SER_DONE;
          end else begin
            valid_d = 1'b1;
            state_d = SER_PRESENT;
`ifdef SERIALIZER_CHECKSUM_EN
            if (last_data) begin
              chk_phase_d = 1'b1;
              data_d      = chk_q;
            end else begin
              elem_d = nxt_elem;
              bsel_d = nxt_bsel;
              data_d = nxt_byte;
              chk_d  = chk_q ^ nxt_byte;
            end
`else
            elem_d = nxt_elem;
            bsel_d = nxt_bsel;
            data_d = nxt_byte;
`endif
          end
        end
      end

      default: begin
        state_d = SER_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SER_IDLE;
      shadow_q <= '0;
      elem_q   <= '0;
      bsel_q   <= '0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      elem_q   <= elem_d;
      bsel_q   <= bsel_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef SERIALIZER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q       <= 8'h00;
      chk_phase_q <= 1'b0;
    end else begin
      chk_q       <= chk_d;
      chk_phase_q <= chk_phase_d;
    end
  end
`endif

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench for result_serializer: randomized results, behavioural byte-stream model,
// host model driving the 4-phase ack, and a monitor comparing every presented byte.
`timescale 1ns/1ps
module tb_result_serializer;
  import mult_pkg::*;

  localparam int SYNC = 2;
  localparam int CW   = N_ELEM * ELEM_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] c_flat;
  logic          ack_in;
  logic [7:0]    data_out;
  logic          valid_out;
  logic          busy;
  logic          done;

  result_serializer #(
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .c_flat    (c_flat),
    .ack_in    (ack_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  int         bytes_seen = 0;

  bit   host_en    = 1'b0;
  bit   host_chk   = 1'b1;
  bit   host_busy  = 1'b0;
  logic ack_force  = 1'b0;
  int   host_delay = 0;
  int   host_lat;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference byte stream: element 0 first, each element as 3 little-endian bytes of its value.
  function automatic void push_expected(input logic [CW-1:0] c);
    logic [7:0]  x;
    logic [31:0] v;
    logic [7:0]  bt;
    x = 8'h00;
    for (int e = 0; e < N_ELEM; e++) begin
      v = 32'(c[e*ELEM_W +: ELEM_W]);
      for (int b = 0; b < BYTES_PER; b++) begin
        bt = 8'((v >> (8*b)) & 32'hFF);
        exp_q.push_back(bt);
        x = x ^ bt;
      end
    end
`ifdef SERIALIZER_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endfunction

  function automatic logic [CW-1:0] rand_c();
    logic [CW-1:0] r;
    r = '0;
    for (int e = 0; e < N_ELEM; e++) r[e*ELEM_W +: ELEM_W] = ELEM_W'($urandom);
    return r;
  endfunction

  // Host: 4-phase handshake with configurable think time; also times each phase.
  initial begin
    ack_in = 1'b0;
    forever begin
      @(negedge clk);
      if (!host_en) begin
        ack_in = ack_force;
      end else if (valid_out) begin
        host_busy = 1'b1;
        repeat (host_delay) @(negedge clk);
        ack_in   = 1'b1;
        host_lat = 0;
        while (valid_out && host_lat < 50) begin
          @(negedge clk);
          host_lat++;
        end
        if (host_chk) check(host_lat == SYNC + 1, "ack_rise_latency", host_lat, SYNC + 1);
        repeat (host_delay) @(negedge clk);
        ack_in   = 1'b0;
        host_lat = 0;
        while (!valid_out && !done && host_lat < 50) begin
          @(negedge clk);
          host_lat++;
        end
        if (host_chk) check(host_lat == SYNC + 1, "ack_fall_latency", host_lat, SYNC + 1);
        host_busy = 1'b0;
      end
    end
  end

  // Monitor: one scoreboard pop per valid_out rise; data must hold until valid_out falls.
  logic       valid_prev = 1'b0;
  logic       done_prev  = 1'b0;
  logic [7:0] held;
  logic [7:0] exp_b;
  bit         stable_ok;

  always @(negedge clk) begin
    if (valid_out && !valid_prev) begin
      bytes_seen++;
      held      = data_out;
      stable_ok = 1'b1;
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_byte", data_out, 0);
      end else begin
        exp_b = exp_q.pop_front();
        check(data_out == exp_b, $sformatf("byte_%0d", bytes_seen), data_out, exp_b);
        $display("byte %0d: data_out=0x%02h expected=0x%02h", bytes_seen, data_out, exp_b);
      end
    end else if (valid_out && data_out != held) begin
      stable_ok = 1'b0;
    end
    if (!valid_out && valid_prev && rst_n)
      check(stable_ok && data_out == held, "data_stable", data_out, held);
    if (done && !done_prev) begin
      check(exp_q.size() == 0, "done_with_bytes_left", exp_q.size(), 0);
      check(!busy, "busy_at_done", busy, 0);
    end
    valid_prev = valid_out;
    done_prev  = done;
  end

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check(done, {tag, "_done_reached"}, done, 1);
    check(exp_q.size() == 0, {tag, "_all_bytes_sent"}, exp_q.size(), 0);
    repeat (2) @(negedge clk);
    check(done && !busy && !valid_out && data_out == 8'h00, {tag, "_done_hold"},
          {done, busy, valid_out, data_out}, {3'b100, 8'h00});
  endtask

  task automatic wait_bytes(input int target, input string tag);
    int cyc;
    cyc = 0;
    while (bytes_seen < target && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check(bytes_seen >= target, {tag, "_byte_progress"}, bytes_seen, target);
  endtask

  task automatic run_stream(input logic [CW-1:0] c, input int dly, input string tag);
    host_delay = dly;
    c_flat     = c;
    push_expected(c);
    start = 1'b1;
    @(negedge clk);
    check(valid_out && busy && !done && data_out == c[7:0], {tag, "_first_byte"},
          {valid_out, busy, done, data_out}, {3'b110, c[7:0]});
    start = 1'b0;
    wait_done(tag);
  endtask

  logic [CW-1:0] c;
  int            base;
  int            cyc;

  initial begin
    rst_n  = 1'b0;
    start  = 1'b1;
    c_flat = '0;

    // Reset held with start high and ack toggling: everything stays quiet.
    for (int i = 0; i < 6; i++) begin
      ack_force = ~ack_force;
      @(negedge clk);
      check({data_out, valid_out, busy, done} == 11'h0, "reset_outputs", {data_out, valid_out, busy, done}, 0);
    end
    ack_force = 1'b0;
    start     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check({data_out, valid_out, busy, done} == 11'h0, "idle_outputs", {data_out, valid_out, busy, done}, 0);
    host_en = 1'b1;
    @(negedge clk);

    // Basic stream with a prompt host.
    c = '0;
    c[0*ELEM_W +: ELEM_W] = 18'h3FFFF;
    c[1*ELEM_W +: ELEM_W] = 18'h12345;
    run_stream(c, 0, "basic");

    // Slow host.
    run_stream(rand_c(), 10, "slow");

    // Start and new results mid-transfer must not disturb the captured stream.
    c          = rand_c();
    c_flat     = c;
    host_delay = 2;
    push_expected(c);
    base  = bytes_seen;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_bytes(base + 6, "midstart");
    c_flat = rand_c();
    start  = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done("midstart");

    // Asynchronous reset mid-transfer, then a full restart from byte 0.
    c          = rand_c();
    c_flat     = c;
    host_delay = 1;
    push_expected(c);
    base  = bytes_seen;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_bytes(base + 13, "midreset");
    host_chk = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check({data_out, valid_out, busy, done} == 11'h0, "async_reset_outputs", {data_out, valid_out, busy, done}, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    while (host_busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check(!host_busy, "host_idle_after_reset", host_busy, 0);
    @(negedge clk);
    host_chk = 1'b1;
    check(!done && !valid_out && !busy, "post_reset_idle", {done, valid_out, busy}, 0);
    run_stream(c, 1, "restart");

    // Checksum-oriented patterns (plain streams when the checksum byte is disabled).
    c = '0;
    c[0*ELEM_W +: ELEM_W] = 18'h00001;
    c[8*ELEM_W +: ELEM_W] = 18'h00100;
    run_stream(c, 0, "chk_a");
    c[8*ELEM_W +: ELEM_W] = 18'h00200;
    run_stream(c, 0, "chk_b");

    // Randomized streams with random host think time.
    for (int i = 0; i < 3; i++) begin
      run_stream(rand_c(), int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/result_serializer.md
# result_serializer

Output stage of the 3×3 array multiplier: captures the nine 18-bit products C[0..8] when the controller enters its OUTPUT phase and streams them off-chip one byte at a time over a 4-phase valid/ack handshake on the TinyTapeout pins. It is the transmit-side counterpart of the byte-serial operand loader. It signals completion to the top-level FSM so the controller can advance OUTPUT → DONE.

## Interface
- N_ELEM, 9: number of result elements.
- ELEM_W, 18: width of each result element; each element occupies BYTES_PER = ceil(ELEM_W/8) = 3 bytes.
- SYNC_STAGES, 2: flops in the ack synchronizer, minimum 2.

- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  level from controller (output_en); sampled only in IDLE or DONE.
- c_flat  in  N_ELEM*ELEM_W  results; element i at bits [i*ELEM_W +: ELEM_W].
- ack_in  in  1  raw host acknowledge pin, asynchronous to clk.
- data_out  out  8  current byte (to uo_out).
- valid_out  out  1  byte on data_out is valid.
- busy  out  1  transfer in progress.
- done  out  1  all bytes acknowledged (output_done).

## Operation
- States: IDLE, PRESENT, WAIT_ACK_LO, DONE.
- IDLE: start=1 → capture c_flat into shadow register, byte index k=0, → PRESENT.
- PRESENT: valid_out=1, data_out = byte k. Synchronized ack=1 → valid_out=0, → WAIT_ACK_LO.
- WAIT_ACK_LO: synchronized ack=0 → if k was last byte → DONE; else k=k+1 → PRESENT.
- DONE: done=1, busy=0. start=1 → recapture, k=0, → PRESENT (done cleared). Otherwise hold.
- Byte order: element 0 first; within an element, little-endian: byte 0 = bits [7:0], byte 1 = [15:8], byte 2 = {6'b0, [17:16]} (zero-extend to 24 bits).
- Total bytes = N_ELEM*BYTES_PER = 27 (28 with checksum, see Configuration).
- Element index and byte-in-element counters; byte counter wraps 2→0 and increments element index; no wrap beyond last element.
- data_out is held stable for the whole of PRESENT and WAIT_ACK_LO; it is 0 in IDLE and DONE.
- start while in PRESENT/WAIT_ACK_LO is ignored; shadow register is not updated mid-transfer.
- ack_in already high on entry to PRESENT: accepted after sync latency (host must honor 4-phase; no lockup).
- Glitch on ack_in shorter than one clk: may or may not be seen; protocol stays consistent because each phase waits for the opposite level.

## Timing
- Reset values: data_out=0, valid_out=0, busy=0, done=0; state IDLE; counters 0; synchronizer flops 0.
- start high at edge N → valid_out=1 and byte 0 on data_out after edge N (first cycle of PRESENT).
- ack_in rise → valid_out falls SYNC_STAGES+1 clk edges later.
- ack_in fall → next byte with valid_out=1 SYNC_STAGES+1 edges later.
- Last ack fall → done=1 SYNC_STAGES+1 edges later; busy falls same edge.
- Minimum per byte with instant host: 2*(SYNC_STAGES+1) cycles.
- rst_n assertion mid-transfer: all outputs to reset values immediately (asynchronous); transfer abandoned, no resume.
- All outputs registered; no combinational path from ack_in or start to any output.

## Configuration
- SERIALIZER_CHECKSUM_EN defined: one extra byte after byte 26 = XOR of all 27 data bytes; done follows its ack. Total 28 bytes.
- Undefined: 27 bytes, no checksum logic, done after byte 26 ack.

## Structure
- Shared package (mult_pkg): N_ELEM, ELEM_W, BYTES_PER, state encoding for the serializer, total-byte-count constant.
- One sub-module: ack_sync (SYNC_STAGES-deep flop chain, reset to 0); reused by the operand loader for its strobe pin.

## Test plan
- Reset: hold rst_n=0 with start=1, ack_in toggling → all outputs 0, no valid_out.
- Basic stream: C[0]=0x3FFFF, C[1]=0x12345, others 0, prompt host → bytes FF FF 03 45 23 01 then 21×00; done=1 after 27th ack fall.
- Slow host: ack delayed 10 cycles per phase → data_out stable while valid_out=1, no byte skipped or repeated.
- Start ignored mid-transfer: change c_flat and pulse start after byte 5 → remaining bytes from originally captured values.
- Reset mid-transfer at byte 12 then restart → stream begins again at byte 0, done only after full 27 bytes.
- SERIALIZER_CHECKSUM_EN: C[0]=0x00001, C[8]=0x00100, others 0 → 28th byte = 0x01 XOR 0x01 = 0x00; with C[8]=0x00200 → 0x03.
